// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns a bouncy active-low push button into clean one-cycle
// step pulses on `enable`, with an optional hold-to-repeat mode and a
// free-running auto-step mode selected by a slide switch.
// Optional feature macro: STEP_PULSE_GEN_REPEAT_EN (auto-repeat while held).
// The default build has the macro undefined and gives one pulse per press.
module step_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int AUTO_PERIOD     = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    input  logic auto,
    output logic enable,
    output logic pressed,
    output logic auto_active
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_B = (REPEAT_PERIOD > AUTO_PERIOD) ? REPEAT_PERIOD : AUTO_PERIOD;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_P);

    localparam logic [TW-1:0] DB_LAST   = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] AUTO_LAST = TW'(AUTO_PERIOD - 1);
`ifdef STEP_PULSE_GEN_REPEAT_EN
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        HELD,
`ifdef STEP_PULSE_GEN_REPEAT_EN
        REPEAT,
`endif
        AUTO,
        WAIT_REL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_next;
    logic          pulse_next;

    logic [1:0]    key_sync;
    logic [1:0]    auto_sync;
    logic          key_s;
    logic          auto_s;
    logic [TW-1:0] db_cnt;
    logic          press_rise;
    logic [1:0]    sync_cnt;
    logic          armed;

    assign key_s  = ~key_sync[1];
    assign auto_s = auto_sync[1];

    // The debounced level is about to rise on this edge; lets IDLE pulse in the same cycle.
    assign press_rise = key_s & ~pressed & (db_cnt == DB_LAST);

    // Two-flop synchronizers; the key chain idles at "released" so reset never looks like a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_sync  <= 2'b11;
            auto_sync <= 2'b00;
        end else begin
            key_sync  <= {key_sync[0], key_n};
            auto_sync <= {auto_sync[0], auto};
        end
    end

    // Debounce: the synchronized key must differ from `pressed` for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt  <= '0;
            pressed <= 1'b0;
        end else if (key_s == pressed) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            pressed <= key_s;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + TW'(1);
        end
    end

    // Arm pressing only once a genuine release has been seen, so a button held through reset gives no pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            if (sync_cnt != 2'd2) begin
                sync_cnt <= sync_cnt + 2'd1;
            end
            if (sync_cnt == 2'd2 && !key_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Next-state, timer and pulse decision; auto mode entry overrides everything else.
    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        pulse_next = 1'b0;
        if (auto_s && state != AUTO) begin
            state_next = AUTO;
            tmr_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    tmr_next = '0;
                    if (press_rise) begin
                        if (armed) begin
                            pulse_next = 1'b1;
                            state_next = HELD;
                        end else begin
                            state_next = WAIT_REL;
                        end
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state_next = IDLE;
                        tmr_next   = '0;
                    end else begin
`ifdef STEP_PULSE_GEN_REPEAT_EN
                        if (tmr == HOLD_LAST) begin
                            pulse_next = 1'b1;
                            state_next = REPEAT;
                            tmr_next   = '0;
                        end else begin
                            tmr_next = tmr + TW'(1);
                        end
`else
                        tmr_next = '0;
`endif
                    end
                end
`ifdef STEP_PULSE_GEN_REPEAT_EN
                REPEAT: begin
                    if (!pressed) begin
                        state_next = IDLE;
                        tmr_next   = '0;
                    end else if (tmr == REPEAT_LAST) begin
                        pulse_next = 1'b1;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr + TW'(1);
                    end
                end
`endif
                AUTO: begin
                    if (!auto_s) begin
                        state_next = pressed ? WAIT_REL : IDLE;
                        tmr_next   = '0;
                    end else if (tmr == AUTO_LAST) begin
                        pulse_next = 1'b1;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr + TW'(1);
                    end
                end
                WAIT_REL: begin
                    tmr_next = '0;
                    if (!pressed) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    tmr_next   = '0;
                end
            endcase
        end
    end

    // State, timer and registered outputs; enable is masked so it can never be high two cycles running.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            tmr         <= '0;
            enable      <= 1'b0;
            auto_active <= 1'b0;
        end else begin
            state       <= state_next;
            tmr         <= tmr_next;
            enable      <= pulse_next & ~enable;
            auto_active <= (state_next == AUTO);
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed testbench for step_pulse_gen with small periods.
// Each scenario drives per-cycle input patterns and compares per-cycle logs of
// enable / pressed / auto_active against hand-computed bit vectors.
// Honours STEP_PULSE_GEN_REPEAT_EN for the repeat-dependent expectations.
module tb_step_pulse_gen;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic key_n = 1'b1;
    logic auto  = 1'b0;
    logic enable;
    logic pressed;
    logic auto_active;

    int num_checks = 0;
    int num_fail   = 0;

    logic [63:0] en_log;
    logic [63:0] pr_log;
    logic [63:0] aa_log;

    step_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_PERIOD  (5),
        .AUTO_PERIOD    (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .auto       (auto),
        .enable     (enable),
        .pressed    (pressed),
        .auto_active(auto_active)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    // Guard against a stuck run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        key_n = 1'b1;
        auto  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    // Bit c of each pattern is driven just after edge c; bit c of each log is sampled just after edge c.
    task automatic applyStimulus(input logic [63:0] keyp, input logic [63:0] autop,
                                 input logic [63:0] rstp, input int n);
        en_log = '0;
        pr_log = '0;
        aa_log = '0;
        key_n  = keyp[0];
        auto   = autop[0];
        reset  = rstp[0];
        for (int c = 1; c <= n; c++) begin
            @(posedge clock);
            #1;
            en_log[c] = enable;
            pr_log[c] = pressed;
            aa_log[c] = auto_active;
            key_n = keyp[c];
            auto  = autop[c];
            reset = rstp[c];
        end
    endtask

    task automatic checkLogs(input string name, input logic [63:0] exp_en,
                             input logic [63:0] exp_pr, input logic [63:0] exp_aa);
        checkOutput({name, ".enable"}, en_log, exp_en);
        checkOutput({name, ".pressed"}, pr_log, exp_pr);
        checkOutput({name, ".auto_active"}, aa_log, exp_aa);
        checkOutput({name, ".no_back_to_back"}, en_log & (en_log << 1), 64'd0);
    endtask

    initial begin
        logic [63:0] low;
        logic [63:0] exp_en;

        // Reset values.
        doReset();
        checkOutput("reset.enable", {63'd0, enable}, 64'd0);
        checkOutput("reset.pressed", {63'd0, pressed}, 64'd0);
        checkOutput("reset.auto_active", {63'd0, auto_active}, 64'd0);

        // Clean press, released before any hold-repeat slot.
        doReset();
        applyStimulus(~rng(0, 7), 64'd0, 64'd0, 30);
        checkLogs("clean_press", rng(6, 6), rng(6, 13), 64'd0);

        // Bounce then a stable press: one pulse 6 cycles after the final falling edge.
        doReset();
        low = rng(0, 1) | rng(4, 5) | rng(8, 15);
        applyStimulus(~low, 64'd0, 64'd0, 30);
        checkLogs("bounce", rng(14, 14), rng(14, 21), 64'd0);

        // Long hold; released so that debounced release lands before the slot at 31.
        doReset();
`ifdef STEP_PULSE_GEN_REPEAT_EN
        exp_en = rng(6, 6) | rng(16, 16) | rng(21, 21) | rng(26, 26);
`else
        exp_en = rng(6, 6);
`endif
        applyStimulus(~rng(0, 23), 64'd0, 64'd0, 40);
        checkLogs("long_hold", exp_en, rng(6, 29), 64'd0);

        // Auto mode with the key chattering; pulses every 8 cycles from entry at edge 3.
        doReset();
        low = '0;
        for (int k = 0; k < 38; k += 4) low |= rng(k, k + 1);
        exp_en = rng(11, 11) | rng(19, 19) | rng(27, 27) | rng(35, 35);
        applyStimulus(~low, rng(0, 37), 64'd0, 50);
        checkLogs("auto_mode", exp_en, 64'd0, rng(3, 40));

        // Leave auto while held: WAIT_REL, silent until release; re-press pulses again.
        doReset();
        low = rng(0, 29) | rng(40, 47);
        applyStimulus(~low, rng(8, 13), 64'd0, 60);
        checkLogs("auto_exit_held", rng(6, 6) | rng(46, 46), rng(6, 35) | rng(46, 53), rng(11, 16));

        // Reset mid-hold: outputs clear, held button gives nothing until released and re-pressed.
        doReset();
`ifdef STEP_PULSE_GEN_REPEAT_EN
        exp_en = rng(6, 6) | rng(16, 16) | rng(46, 46);
`else
        exp_en = rng(6, 6) | rng(46, 46);
`endif
        low = rng(0, 29) | rng(40, 47);
        applyStimulus(~low, 64'd0, rng(18, 18), 60);
        checkLogs("reset_mid_hold", exp_en, rng(6, 18) | rng(25, 35) | rng(46, 53), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
